mux_scan_seq: RTL and testbench



---
 rtl/mux_scan_seq_pkg.sv | 23 ++
 rtl/mux_scan_seq_ser_out.sv | 26 ++
 rtl/mux_scan_seq.sv | 117 +++++++++++
 tb/tb_mux_scan_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_seq_pkg.sv
// Shared types and defaults for the mux scan sequencer.
// Optional feature macro: SCAN_PARITY_EN (adds the PAR state for an even-parity trailer bit).
package mux_scan_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SEL_W_DEF = 3;

`ifdef SCAN_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    PAR   = 2'd2,
    DRAIN = 2'd3
  } scan_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd3
  } scan_state_t;
`endif

endpackage

// File: rtl/mux_scan_seq_ser_out.sv
// Serial output register: loads a new bit on step, drops valid on a plain
// acceptance, and otherwise holds bit and valid steady under backpressure.
module ser_out_reg (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic bit_in,
  input  logic clr,
  output logic ser_bit,
  output logic ser_valid
);

  // Load on step, retire on acceptance, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
    end else if (step) begin
      ser_bit   <= bit_in;
      ser_valid <= 1'b1;
    end else if (clr) begin
      ser_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Upstream sequencer for an external 8:1 mux: latches a parallel word onto the
// mux data inputs, walks the select from 0 to WIDTH-1 and streams the sampled
// mux output LSB first over a valid/ready serial interface.
// Optional feature macro: SCAN_PARITY_EN (appends an even-parity bit of mux_i).
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] mux_i,
  output logic [SEL_W-1:0] mux_s,
  input  logic             mux_y,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

  scan_state_t state;
  logic        can_step;
  logic        step_en;
  logic        step_bit;
  logic        ser_clr;

  // Step qualification and the bit to capture on a step
  always_comb begin
    can_step = ~ser_valid | ser_ready;
    ser_clr  = ser_valid & ser_ready;
    step_en  = 1'b0;
    step_bit = mux_y;
    if (state == SCAN) begin
      step_en = can_step;
    end
`ifdef SCAN_PARITY_EN
    if (state == PAR) begin
      step_en  = can_step;
      // Parity comes from the latched word, not from the mux samples
      step_bit = ^mux_i;
    end
`endif
  end

  // Sequencer FSM with registered handshake and mux drive outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      mux_i      <= '0;
      mux_s      <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            mux_i      <= data_in;
            mux_s      <= '0;
            load_ready <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (can_step) begin
            if (mux_s == LAST_SEL) begin
              mux_s <= '0;
`ifdef SCAN_PARITY_EN
              state <= PAR;
`else
              state <= DRAIN;
`endif
            end else begin
              mux_s <= mux_s + SEL_W'(1);
            end
          end
        end
`ifdef SCAN_PARITY_EN
        PAR: begin
          if (can_step) begin
            state <= DRAIN;
          end
        end
`endif
        DRAIN: begin
          // Last bit leaves when it is accepted; IDLE and done appear together
          if (ser_valid && ser_ready) begin
            done       <= 1'b1;
            load_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  ser_out_reg u_ser_out (
    .clk       (clk),
    .rst       (rst),
    .step      (step_en),
    .bit_in    (step_bit),
    .clr       (ser_clr),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid)
  );

endmodule

// File: tb/tb_mux_scan_seq.sv
// Testbench for mux_scan_seq with a behavioural 8:1 mux closing the loop.
module tb_mux_scan_seq;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;
`ifdef SCAN_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] mux_i;
  logic [SEL_W-1:0] mux_s;
  logic             mux_y;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_ready = 1'b1;
  logic             done;

  int checks = 0;
  int errors = 0;
  int bits_acc = 0;
  int done_cnt = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  // Stand-in for the external mux_8_1: y = i[s]
  assign mux_y = mux_i[mux_s];

  mux_scan_seq #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .mux_i      (mux_i),
    .mux_s      (mux_s),
    .mux_y      (mux_y),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on each accepted bit, hold check during stalls
  initial begin
    logic prev_stall;
    logic prev_bit;
    logic [SEL_W-1:0] prev_s;
    logic e;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
    prev_s     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (prev_stall) begin
          chk("stall_valid", 32'(ser_valid), 32'd1);
          chk("stall_bit", 32'(ser_bit), 32'(prev_bit));
          chk("stall_sel", 32'(mux_s), 32'(prev_s));
        end
        if (ser_valid && ser_ready) begin
          bits_acc++;
          if (exp_q.size() == 0) begin
            chk("extra_bit", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("ser_bit", 32'(ser_bit), 32'(e));
          end
        end
        prev_stall = ser_valid && !ser_ready;
        prev_bit   = ser_bit;
        prev_s     = mux_s;
      end
    end
  end

  task automatic load_word(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!load_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("load_ready_wait", 32'(load_ready), 32'd1);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
`ifdef SCAN_PARITY_EN
    exp_q.push_back(^w);
`endif
    data_in    = w;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Returns negedge index of done and of first ser_valid after the load edge
  task automatic wait_done(output int k, output int first_v);
    logic lr_early;
    lr_early = 1'b0;
    k = -1;
    first_v = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ser_valid && first_v < 0) first_v = i;
      if (done) begin
        k = i;
        break;
      end
      if (load_ready) lr_early = 1'b1;
    end
    chk("done_seen", 32'(k >= 0), 32'd1);
    if (k >= 0) begin
      chk("ready_with_done", 32'(load_ready), 32'd1);
      chk("valid_after_done", 32'(ser_valid), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("ready_low_in_scan", 32'(lr_early), 32'd0);
    end
  endtask

  initial begin
    int k;
    int fv;
    int n;
    int d0;
    int b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_mux_i", 32'(mux_i), 32'd0);
    chk("rst_mux_s", 32'(mux_s), 32'd0);
    chk("rst_ser_bit", 32'(ser_bit), 32'd0);
    chk("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic scan with latency
    b0 = bits_acc;
    load_word(8'hA5);
    chk("basic_mux_i", 32'(mux_i), 32'hA5);
    wait_done(k, fv);
    chk("basic_first_valid", 32'(fv), 32'd1);
    chk("basic_done_cycle", 32'(k), 32'(FRAME + 1));
    chk("basic_bits", 32'(bits_acc - b0), 32'(FRAME));

    // One-hot sweep: select 0 and select 7
    load_word(8'b0000_0001);
    wait_done(k, fv);
    load_word(8'b1000_0000);
    wait_done(k, fv);

    // Backpressure at the 3rd and 7th bits
    d0 = done_cnt;
    load_word(8'hF0);
    n = 0;
    while (!(ser_valid && mux_s == 3'd3) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("bp1_reached", 32'(mux_s), 32'd3);
    ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp1_frozen_sel", 32'(mux_s), 32'd3);
    ser_ready = 1'b1;
    n = 0;
    while (!(ser_valid && mux_s == 3'd7) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("bp2_reached", 32'(mux_s), 32'd7);
    ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp2_frozen_sel", 32'(mux_s), 32'd7);
    ser_ready = 1'b1;
    wait_done(k, fv);
    repeat (3) @(negedge clk);
    chk("bp_one_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-scan after the 4th bit
    d0 = done_cnt;
    b0 = bits_acc;
    load_word(8'hFF);
    n = 0;
    while ((bits_acc - b0) < 4 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_load_ready", 32'(load_ready), 32'd1);
    chk("mid_rst_mux_i", 32'(mux_i), 32'd0);
    chk("mid_rst_mux_s", 32'(mux_s), 32'd0);
    chk("mid_rst_ser_bit", 32'(ser_bit), 32'd0);
    chk("mid_rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    load_word(8'h0F);
    wait_done(k, fv);

    // Ignored load during SCAN
    load_word(8'h3C);
    repeat (2) @(posedge clk);
    #1;
    data_in    = 8'h00;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    chk("ignored_load_ready", 32'(load_ready), 32'd0);
    chk("ignored_mux_i", 32'(mux_i), 32'h3C);
    wait_done(k, fv);

`ifdef SCAN_PARITY_EN
    // Parity trailer: odd and even popcount words
    load_word(8'h07);
    wait_done(k, fv);
    load_word(8'h03);
    wait_done(k, fv);
`endif

    repeat (2) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
